// File: rtl/counter_arb_pkg.sv
// Shared definitions for the counter access arbiter: opcodes, FSM states, flag layout.
package counter_arb_pkg;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    // Bit positions inside rsp_flags = {ovf_seen, udf_seen, zero}.
    localparam int unsigned FLAG_OVF  = 2;
    localparam int unsigned FLAG_UDF  = 1;
    localparam int unsigned FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StSettle,
        StResp
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] grant_idx_o
);

    // Scan from the pointer; the index is reported even when advance_i masks the grant.
    always_comb begin
        logic        found;
        int unsigned idx;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = advance_i;
                grant_idx_o  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/counter_access_arbiter.sv
// Shares one up/down counter between NUM_REQ requesters: arbitrate, drive the
// counter controls for the granted command, wait for the output to settle, respond.
module counter_access_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned COUNTER_WIDTH = 12,
    parameter int unsigned STEP_WIDTH    = 8,
    localparam int unsigned IdW          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [2*NUM_REQ-1:0]             req_op,
    input  logic [COUNTER_WIDTH*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [IdW-1:0]                   rsp_id,
    output logic [COUNTER_WIDTH-1:0]         rsp_data,
    output logic [2:0]                       rsp_flags,
    output logic                             cnt_enable,
    output logic                             cnt_direction,
    output logic                             cnt_load,
    output logic [COUNTER_WIDTH-1:0]         cnt_load_value,
    input  logic [COUNTER_WIDTH-1:0]         cnt_value,
    input  logic                             cnt_overflow,
    input  logic                             cnt_underflow,
    input  logic                             cnt_zero
);

    arb_state_e                state_q;
    logic [IdW-1:0]            ptr_q;
    logic [1:0]                op_q;
    logic [STEP_WIDTH-1:0]     steps_q;
    logic                      settle_q;
    logic                      ovf_q;
    logic                      udf_q;
    logic                      rsp_valid_q;
    logic [IdW-1:0]            rsp_id_q;
    logic [COUNTER_WIDTH-1:0]  rsp_data_q;
    logic [2:0]                rsp_flags_q;
    logic                      cnt_enable_q;
    logic                      cnt_direction_q;
    logic                      cnt_load_q;
    logic [COUNTER_WIDTH-1:0]  cnt_load_value_q;

    logic [NUM_REQ-1:0]        grant;
    logic [IdW-1:0]            grant_idx;
    logic [1:0]                g_op;
    logic [COUNTER_WIDTH-1:0]  g_data;
    logic [STEP_WIDTH-1:0]     g_steps;
    logic                      advance;

    // Grants only in IDLE; gating with rst_n keeps req_ready low while reset is held.
    assign advance = (state_q == StIdle) && rst_n;

    rr_arbiter #(
        .N    (NUM_REQ),
        .IdxW (IdW)
    ) u_rr (
        .req_i       (req_valid),
        .advance_i   (advance),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign g_op    = req_op[int'(grant_idx)*2 +: 2];
    assign g_data  = req_data[int'(grant_idx)*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign g_steps = g_data[STEP_WIDTH-1:0];

    assign req_ready      = grant;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_flags      = rsp_flags_q;
    assign cnt_enable     = cnt_enable_q;
    assign cnt_direction  = cnt_direction_q;
    assign cnt_load       = cnt_load_q;
    assign cnt_load_value = cnt_load_value_q;

    // Command sequencer with registered counter controls and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            ptr_q            <= '0;
            op_q             <= OP_READ;
            steps_q          <= '0;
            settle_q         <= 1'b0;
            ovf_q            <= 1'b0;
            udf_q            <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_id_q         <= '0;
            rsp_data_q       <= '0;
            rsp_flags_q      <= '0;
            cnt_enable_q     <= 1'b0;
            cnt_direction_q  <= 1'b0;
            cnt_load_q       <= 1'b0;
            cnt_load_value_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|grant) begin
                        op_q     <= g_op;
                        steps_q  <= g_steps;
                        rsp_id_q <= grant_idx;
                        ptr_q    <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IdW'(1);
                        ovf_q    <= 1'b0;
                        udf_q    <= 1'b0;
                        settle_q <= 1'b0;
                        if (g_op == OP_LOAD) begin
                            cnt_load_q       <= 1'b1;
                            cnt_load_value_q <= g_data;
                            state_q          <= StExec;
                        end else if (g_op != OP_READ && g_steps != '0) begin
                            cnt_enable_q    <= 1'b1;
                            cnt_direction_q <= g_op[0];
                            state_q         <= StExec;
                        end else begin
                            state_q <= StSettle;
                        end
                    end
                end
                StExec: begin
                    ovf_q <= ovf_q | cnt_overflow;
                    udf_q <= udf_q | cnt_underflow;
                    if (op_q == OP_LOAD) begin
                        cnt_load_q       <= 1'b0;
                        cnt_load_value_q <= '0;
                        state_q          <= StSettle;
                    end else begin
                        steps_q <= steps_q - STEP_WIDTH'(1);
                        if (steps_q == STEP_WIDTH'(1)) begin
                            cnt_enable_q    <= 1'b0;
                            cnt_direction_q <= 1'b0;
                            state_q         <= StSettle;
                        end
                    end
                end
                StSettle: begin
                    ovf_q <= ovf_q | cnt_overflow;
                    udf_q <= udf_q | cnt_underflow;
                    if (!settle_q) begin
                        settle_q <= 1'b1;
                    end else begin
                        // Last settle cycle: the counter's output register now reflects the command.
                        rsp_data_q            <= cnt_value;
                        rsp_flags_q[FLAG_OVF] <= ovf_q | cnt_overflow;
                        rsp_flags_q[FLAG_UDF] <= udf_q | cnt_underflow;
                        rsp_flags_q[FLAG_ZERO] <= cnt_zero;
                        rsp_valid_q           <= 1'b1;
                        state_q               <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Bench for counter_access_arbiter with a behavioural 11-bit-range counter attached.
module tb_counter_access_arbiter;

    localparam int NR = 4;
    localparam int CW = 12;
    localparam int SW = 8;
    localparam int CMAX = 2047;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [2*NR-1:0]   req_op;
    logic [CW*NR-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [CW-1:0]     rsp_data;
    logic [2:0]        rsp_flags;
    logic              cnt_enable;
    logic              cnt_direction;
    logic              cnt_load;
    logic [CW-1:0]     cnt_load_value;
    logic [CW-1:0]     cnt_value;
    logic              cnt_overflow;
    logic              cnt_underflow;
    logic              cnt_zero;

    always #5 clk = ~clk;

    counter_access_arbiter #(
        .NUM_REQ       (NR),
        .COUNTER_WIDTH (CW),
        .STEP_WIDTH    (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_flags      (rsp_flags),
        .cnt_enable     (cnt_enable),
        .cnt_direction  (cnt_direction),
        .cnt_load       (cnt_load),
        .cnt_load_value (cnt_load_value),
        .cnt_value      (cnt_value),
        .cnt_overflow   (cnt_overflow),
        .cnt_underflow  (cnt_underflow),
        .cnt_zero       (cnt_zero)
    );

    // Attached counter: wraps modulo 2048, flags and value delayed by one output register.
    logic [CW-1:0] m_count;
    logic          m_ovf, m_udf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= '0; m_ovf <= 1'b0; m_udf <= 1'b0;
            cnt_value <= '0; cnt_overflow <= 1'b0; cnt_underflow <= 1'b0;
        end else begin
            m_ovf <= 1'b0;
            m_udf <= 1'b0;
            if (cnt_load) begin
                m_count <= cnt_load_value;
            end else if (cnt_enable) begin
                if (!cnt_direction) begin
                    if (m_count == CW'(CMAX)) begin m_count <= '0; m_ovf <= 1'b1; end
                    else m_count <= m_count + 1'b1;
                end else begin
                    if (m_count == '0) begin m_count <= CW'(CMAX); m_udf <= 1'b1; end
                    else m_count <= m_count - 1'b1;
                end
            end
            cnt_value     <= m_count;
            cnt_overflow  <= m_ovf;
            cnt_underflow <= m_udf;
        end
    end
    assign cnt_zero = (cnt_value == '0);

    typedef struct {
        logic [1:0]    id;
        logic [CW-1:0] data;
        logic [2:0]    flags;
        int            lat;
        int            steps;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            model_ptr = 0;
    logic [CW-1:0] model_val = '0;

    // Reference model of one command; pushes the expected response.
    task automatic push_expect(input int id, input logic [1:0] op, input logic [CW-1:0] d);
        exp_t e;
        int   v, n;
        logic ovf, udf;
        v = int'(model_val); ovf = 1'b0; udf = 1'b0;
        n = int'(d[SW-1:0]);
        e.id = 2'(id);
        e.steps = 0;
        case (op)
            2'b00: e.lat = 3;
            2'b01: begin v = int'(d); e.lat = 4; end
            2'b10: begin
                for (int i = 0; i < n; i++) begin
                    if (v == CMAX) begin v = 0; ovf = 1'b1; end else v = v + 1;
                end
                e.lat = (n == 0) ? 3 : n + 3; e.steps = n;
            end
            default: begin
                for (int i = 0; i < n; i++) begin
                    if (v == 0) begin v = CMAX; udf = 1'b1; end else v = v - 1;
                end
                e.lat = (n == 0) ? 3 : n + 3; e.steps = n;
            end
        endcase
        model_val = CW'(v);
        e.data = CW'(v);
        e.flags = {ovf, udf, (v == 0)};
        sb.push_back(e);
    endtask

    task automatic drive_req(input int id, input logic [1:0] op, input logic [CW-1:0] d);
        req_op[id*2 +: 2]    = op;
        req_data[id*CW +: CW] = d;
        req_valid[id]        = 1'b1;
    endtask

    // Raise one request, wait for its accept pulse, record the expectation.
    task automatic issue(input int id, input logic [1:0] op, input logic [CW-1:0] d);
        logic [NR-1:0] exp_g;
        @(negedge clk);
        drive_req(id, op, d);
        #1;
        for (int w = 0; w < 20 && req_ready == '0; w++) begin
            @(negedge clk); #1;
        end
        exp_g = '0; exp_g[id] = 1'b1;
        checks++;
        if (req_ready !== exp_g) begin
            errors++;
            $display("FAIL grant_req%0d: req_ready=%b required %b", id, req_ready, exp_g);
        end
        push_expect(id, op, d);
        model_ptr = (id + 1) % NR;
    endtask

    // From the accept cycle: follow the command, check latency/controls/response, handshake.
    task automatic collect(input int stall, input logic [NR-1:0] side_valid);
        int   lat = 0, bad_ready = 0, en_cnt = 0, both = 0, bad_hold = 0;
        bit   got = 1'b0;
        exp_t e;
        logic [1:0] h_id; logic [CW-1:0] h_data; logic [2:0] h_flags;
        while (lat < 200) begin
            @(negedge clk); #1;
            lat++;
            if (lat == 1) req_valid = side_valid;
            if (rsp_valid) begin got = 1'b1; break; end
            if (req_ready != '0) bad_ready++;
            if (cnt_enable) en_cnt++;
            if (cnt_enable && cnt_load) both++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 200 cycles", rsp_valid);
            req_valid = '0;
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checks += 7;
        if (lat != e.lat) begin errors++;
            $display("FAIL latency: got %0d required %0d", lat, e.lat); end
        if (rsp_id !== e.id) begin errors++;
            $display("FAIL rsp_id: got %0d required %0d", rsp_id, e.id); end
        if (rsp_data !== e.data) begin errors++;
            $display("FAIL rsp_data: got %h required %h", rsp_data, e.data); end
        if (rsp_flags !== e.flags) begin errors++;
            $display("FAIL rsp_flags: got %b required %b", rsp_flags, e.flags); end
        if (en_cnt != e.steps) begin errors++;
            $display("FAIL enable_cycles: got %0d required %0d", en_cnt, e.steps); end
        if (both != 0) begin errors++;
            $display("FAIL load_and_enable: got %0d cycles required 0", both); end
        if (bad_ready != 0) begin errors++;
            $display("FAIL ready_while_busy: got %0d cycles required 0", bad_ready); end
        h_id = rsp_id; h_data = rsp_data; h_flags = rsp_flags;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_id !== h_id || rsp_data !== h_data ||
                rsp_flags !== h_flags || req_ready != '0) bad_hold++;
        end
        rsp_ready = 1'b1;
        if (req_ready != '0) bad_hold++;
        if (stall > 0) begin
            checks++;
            if (bad_hold != 0) begin errors++;
                $display("FAIL rsp_hold: %0d unstable cycles required 0", bad_hold); end
        end
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL rsp_drop: rsp_valid=%b required 0", rsp_valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '1; req_op = '0; req_data = '0;
        #12;
        checks += 3;
        if (req_ready !== '0) begin errors++;
            $display("FAIL reset_ready: got %b required 0", req_ready); end
        if ({rsp_valid, rsp_id, rsp_data, rsp_flags} !== '0) begin errors++;
            $display("FAIL reset_rsp: got %b/%0d/%h/%b required 0", rsp_valid, rsp_id,
                     rsp_data, rsp_flags); end
        if ({cnt_enable, cnt_direction, cnt_load, cnt_load_value} !== '0) begin errors++;
            $display("FAIL reset_cnt: got %b%b%b/%h required 0", cnt_enable, cnt_direction,
                     cnt_load, cnt_load_value); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_val = '0; model_ptr = 0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_g;
        @(negedge clk);
        req_op = '0; req_data = '0; req_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_g = '0; exp_g[model_ptr] = 1'b1;
            checks++;
            if (req_ready !== exp_g) begin errors++;
                $display("FAIL rr_grant%0d: got %b required %b", k, req_ready, exp_g); end
            push_expect(model_ptr, 2'b00, '0);
            model_ptr = (model_ptr + 1) % NR;
            collect(0, (k == 4) ? 4'b0000 : 4'b1111);
        end
    endtask

    task automatic test_load_up();
        issue(0, 2'b01, 12'h000); collect(0, '0);
        issue(0, 2'b10, 12'h005); collect(0, '0);
    endtask

    task automatic test_wrap();
        issue(1, 2'b01, 12'h7FF); collect(0, '0);
        issue(1, 2'b10, 12'h001); collect(0, '0);
        issue(1, 2'b11, 12'h001); collect(0, '0);
    endtask

    task automatic test_zero_step();
        issue(2, 2'b10, 12'hF00); collect(0, '0);
    endtask

    task automatic test_step_width();
        issue(3, 2'b11, 12'h203); collect(0, '0);
        issue(0, 2'b10, 12'hA07); collect(0, '0);
    endtask

    task automatic test_stall();
        req_op[1:0] = 2'b00; req_data[CW-1:0] = '0;
        issue(3, 2'b00, 12'h000);
        collect(10, 4'b0001);
        checks++;
        if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL post_handshake_grant: got %b required 0001", req_ready); end
        push_expect(0, 2'b00, '0);
        model_ptr = 1;
        collect(0, '0);
    endtask

    task automatic test_reset_mid();
        issue(2, 2'b10, 12'd20);
        @(negedge clk); #1;
        req_valid = '0;
        repeat (4) begin @(negedge clk); end
        #1;
        checks++;
        if (cnt_enable !== 1'b1) begin errors++;
            $display("FAIL exec_enable: got %b required 1", cnt_enable); end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (cnt_enable !== 1'b0) begin errors++;
            $display("FAIL reset_drop_enable: got %b required 0", cnt_enable); end
        if (rsp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_drop_rsp: got %b required 0", rsp_valid); end
        void'(sb.pop_back());
        model_val = '0; model_ptr = 0;
        req_op = '0; req_data = '0; req_valid = '1;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== '0) begin errors++;
            $display("FAIL ready_in_reset: got %b required 0", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++;
            $display("FAIL grant_after_reset: got %b required 0001", req_ready); end
        push_expect(0, 2'b00, '0);
        model_ptr = 1;
        collect(0, '0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_load_up();
        test_wrap();
        test_zero_step();
        test_step_width();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
